// File: rtl/truth_table_sequencer.sv
// Clocked sweep of a small combinational unit through every input vector.
// The captured truth table is compared against a pattern latched at start.
module truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match
);

  localparam int                W          = 1 << N_IN;
  localparam logic [N_IN-1:0]   LAST_IDX   = {N_IN{1'b1}};
  localparam logic [3:0]        SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] index_q, index_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [3:0]      count_q, count_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [W-1:0]    table_q, table_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            match_q, match_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    exp_d   = exp_q;
    table_d = table_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          exp_d   = expected;
          table_d = '0;
          match_d = 1'b0;
          index_d = '0;
          count_d = '0;
        end
      end
      RUN: begin
        if (count_q != SETTLE_CNT) begin
          count_d = count_q + 4'd1;
        end else begin
          count_d          = '0;
          table_d[index_q] = dut_out;
          // Compare against the table including the bit captured this edge.
          if (index_q == LAST_IDX) begin
            state_d = DONE;
            match_d = (table_d == exp_q);
          end else begin
            index_d = index_q + N_IN'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are derived from the next state so they leave the flops aligned with it.
    busy_d   = (state_d == RUN);
    done_d   = (state_d == DONE);
    dut_in_d = (state_d == RUN) ? index_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      index_q  <= '0;
      count_q  <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      match_q  <= match_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign match     = match_q;

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer that exercises a combinational logic unit with up to four inputs, such as the two-input `s = ~a & b` gate, through every input combination. For each vector it waits a programmable settle time, samples the unit's output, and assembles the results into a truth-table word. At the end it compares that word against an expected pattern and reports the outcome with a start/busy/done handshake. It sits between a test or control host and the gate under exercise, replacing hand-written `#1` stimulus sequences with a clocked, self-checking sweep.

## Interface
- `N_IN`, default 2: number of inputs of the exercised unit; legal range 1..4.
- `SETTLE`, default 1: extra cycles each vector is held before sampling; legal range 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `expected`  in  2**N_IN  expected truth table; bit i is the output for input vector i; latched when `start` is accepted.
- `dut_in`  out  N_IN  vector driven to the unit; MSB is the first input (`a`), LSB is the last (`b`).
- `dut_out`  in  1  unit output (`s`), sampled at the end of each vector window.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `table_out`  out  2**N_IN  captured truth table; bit i is `dut_out` sampled while `dut_in` equals i.
- `match`  out  1  high when `table_out` equals the latched `expected`; valid from `done` until the next accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `dut_in`=0 and `busy`=0. If `start`=1 at an edge, the block latches `expected`, clears `table_out` and `match`, sets vector index=0 and settle count=0, and goes to RUN.
- RUN: `busy`=1 and `dut_in`=index. At each edge:
  - If count < SETTLE, count increments.
  - Otherwise `table_out[index]` is loaded from `dut_out` and count resets to 0.
  - If index = 2**N_IN-1, the block goes to DONE and `match` is set to `({dut_out, other captured bits} == expected)`, which includes the bit just captured. Otherwise index increments.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then unconditional return to IDLE. `dut_in` returns to 0.
- `table_out` and `match` hold their values in IDLE until the next accepted `start`.
- A `start` asserted in RUN or DONE is ignored and is not queued. A `start` held high continuously begins a new sweep on the first IDLE edge.
- Changes on `expected` after acceptance have no effect on the current sweep.
- Index width is N_IN bits. The sweep ends after vector 2**N_IN-1; the index never wraps into a second pass.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, `dut_in`=0, `busy`=0, `done`=0, `table_out`=0, `match`=0, internal index, count and latched expected all 0. Outputs clear immediately, without waiting for an edge.
- Reset mid-sweep aborts the sweep with no `done` pulse. After release the block waits in IDLE for `start`.
- Each vector is driven for SETTLE+1 cycles. The sample is taken at the edge that ends its window.
- Let E0 be the edge that accepts `start`:
  - `busy` rises after E0.
  - `done` rises after edge E0 + 2**N_IN*(SETTLE+1) and falls one edge later.
  - Start-to-done latency is 2**N_IN*(SETTLE+1) cycles. For the defaults this is 8.
- Minimum spacing between accepted `start` pulses is 2**N_IN*(SETTLE+1)+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Defaults, `dut_out` = ~a & b, `expected`=4'b0010, start pulsed for one cycle:
  - `dut_in` steps 0,1,2,3, each held 2 cycles.
  - `done` pulses 8 cycles after acceptance, with `table_out`=4'b0010 and `match`=1.
- Same sweep with `dut_out` = a & b and `expected`=4'b0010: `table_out`=4'b1000, `match`=0.
- SETTLE=0, `dut_out` = a | b, `expected`=4'b1110: each vector is held 1 cycle, `done` arrives 4 cycles after acceptance, `match`=1.
- `start` re-pulsed in RUN and in the DONE cycle, and `expected` changed mid-sweep:
  - Neither `start` pulse starts a new sweep; exactly one `done` pulse occurs.
  - The result uses the originally latched `expected`.
  - A `start` in the following IDLE cycle is accepted.
- `rst_n` driven low at cycle 3 of a sweep:
  - `busy`, `dut_in`, `table_out` and `match` read 0 before the next edge, and no `done` pulse occurs.
  - After release, a new sweep completes normally with `table_out`=4'b0010.
- N_IN=3, SETTLE=2, `dut_out`=~a & b & c: 8 vectors of 3 cycles each, `done` after 24 cycles, `table_out`=8'b0000_1000.
